// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared mode encodings, default thresholds and parameter checks for key_bank
package key_pkg;

    typedef enum logic {
        KEY_MODE_DIRECT = 1'b0,
        KEY_MODE_TOGGLE = 1'b1
    } key_mode_e;

    function automatic int unsigned key_cnt_max(input int cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

    function automatic int unsigned key_hi_th(input int cnt_w);
        return (32'd1 << cnt_w) - (32'd1 << (cnt_w - 3));
    endfunction

    function automatic int unsigned key_lo_th(input int cnt_w);
        return 32'd1 << (cnt_w - 1);
    endfunction

    function automatic bit key_params_ok(
        input int          cnt_w,
        input int unsigned hi_th,
        input int unsigned lo_th,
        input int          rpt_w,
        input int unsigned rpt_delay,
        input int unsigned rpt_period
    );
        // Upper width bounds keep the shifts above inside 32-bit arithmetic
        if (cnt_w < 3 || cnt_w > 31) return 1'b0;
        if (!(lo_th < hi_th && hi_th <= key_cnt_max(cnt_w))) return 1'b0;
        if (rpt_w < 1 || rpt_w > 31) return 1'b0;
        if (rpt_period < 1 || rpt_delay < rpt_period) return 1'b0;
        if (rpt_delay > key_cnt_max(rpt_w)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit key_channels_ok(input int channels);
        return (channels >= 1) && (channels <= 32);
    endfunction

endpackage

// File: rtl/key_chan.sv
// rtl/key_chan.sv - one debounced key channel; auto-repeat built with KEY_BANK_AUTOREPEAT_EN
module key_chan
    import key_pkg::*;
#(
    parameter int          CNT_W      = 16,
    parameter int unsigned HI_TH      = key_hi_th(CNT_W),
    parameter int unsigned LO_TH      = key_lo_th(CNT_W),
    parameter int          RPT_W      = 24,
    parameter int unsigned RPT_DELAY  = 32'd1 << 23,
    parameter int unsigned RPT_PERIOD = 32'd1 << 21
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    input  logic mode_i,
    output logic raw_o,
    output logic level_o,
    output logic press_o,
    output logic rise_o,
    output logic fall_o,
    output logic repeat_o
);

    if (!key_params_ok(CNT_W, HI_TH, LO_TH, RPT_W, RPT_DELAY, RPT_PERIOD)) begin : g_param_err
        $error("key_chan: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HI      = CNT_W'(HI_TH);
    localparam logic [CNT_W-1:0] LO      = CNT_W'(LO_TH);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             raw;

    assign raw = sync_q[1];

    always_comb begin
        cnt_d = cnt_q;
        if (raw && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!raw && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        // Thresholds are judged on the next count so events land on the same edge
        level_d = level_q;
        if (raw && cnt_d >= HI) begin
            level_d = 1'b1;
        end else if (!raw && cnt_d < LO) begin
            level_d = 1'b0;
        end

        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;

        if (key_mode_e'(mode_i) == KEY_MODE_TOGGLE) begin
            press_d = rise_d ? ~press_q : press_q;
        end else begin
            press_d = level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], in_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef KEY_BANK_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] DELAY  = RPT_W'(RPT_DELAY);
    localparam logic [RPT_W-1:0] RELOAD = RPT_W'(RPT_DELAY - RPT_PERIOD);

    logic [RPT_W-1:0] tmr_q, tmr_d, tmr_inc;
    logic             rpt_q, rpt_d;

    assign tmr_inc = tmr_q + 1'b1;

    always_comb begin
        tmr_d = tmr_q;
        rpt_d = 1'b0;
        if (!level_d || !level_q) begin
            // Idle, fall or rise: restart the hold measurement
            tmr_d = '0;
        end else if (tmr_inc == DELAY) begin
            tmr_d = RELOAD;
            rpt_d = 1'b1;
        end else begin
            tmr_d = tmr_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmr_q <= '0;
            rpt_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            rpt_q <= rpt_d;
        end
    end

    assign repeat_o = rpt_q;
`else
    assign repeat_o = 1'b0;
`endif

    assign raw_o   = raw;
    assign level_o = level_q;
    assign press_o = press_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/key_bank.sv
// rtl/key_bank.sv - multi-channel key debouncer; auto-repeat built with KEY_BANK_AUTOREPEAT_EN
module key_bank
    import key_pkg::*;
#(
    parameter int          CHANNELS   = 4,
    parameter int          CNT_W      = 16,
    parameter int unsigned HI_TH      = key_hi_th(CNT_W),
    parameter int unsigned LO_TH      = key_lo_th(CNT_W),
    parameter int          RPT_W      = 24,
    parameter int unsigned RPT_DELAY  = 32'd1 << 23,
    parameter int unsigned RPT_PERIOD = 32'd1 << 21
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] in_i,
    input  logic [CHANNELS-1:0] mode_i,
    output logic [CHANNELS-1:0] raw_o,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] repeat_o
);

    if (!key_channels_ok(CHANNELS)) begin : g_chan_err
        $error("key_bank: CHANNELS must be 1..32");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        key_chan #(
            .CNT_W      (CNT_W),
            .HI_TH      (HI_TH),
            .LO_TH      (LO_TH),
            .RPT_W      (RPT_W),
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .in_i     (in_i[i]),
            .mode_i   (mode_i[i]),
            .raw_o    (raw_o[i]),
            .level_o  (level_o[i]),
            .press_o  (press_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i]),
            .repeat_o (repeat_o[i])
        );
    end

endmodule

// File: tb/tb_key_bank.sv
// tb/tb_key_bank.sv - directed self-checking bench for key_bank (KEY_BANK_AUTOREPEAT_EN aware)
module tb_key_bank;

`ifdef KEY_BANK_AUTOREPEAT_EN
    localparam logic AR = 1'b1;
`else
    localparam logic AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_v;
    logic [1:0] mode_v;
    logic [1:0] raw, level, press, rise, fall, rpt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_bank #(
        .CHANNELS   (2),
        .CNT_W      (4),
        .HI_TH      (12),
        .LO_TH      (4),
        .RPT_W      (8),
        .RPT_DELAY  (20),
        .RPT_PERIOD (8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .in_i     (in_v),
        .mode_i   (mode_v),
        .raw_o    (raw),
        .level_o  (level),
        .press_o  (press),
        .rise_o   (rise),
        .fall_o   (fall),
        .repeat_o (rpt)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        in_v   = 2'b00;
        mode_v = 2'b00;
        step(3);
        chk("reset_all", {raw, level, press, rise, fall, rpt}, 32'h0);
        rst = 1'b0;
        step(2);

        // Direct-mode press on channel 0
        in_v = 2'b01;
        step(13);
        chk("p0_level_e13", {level, rise}, 4'b0000);
        step(1);
        chk("p0_e14_ch0", {level[0], rise[0], press[0]}, 3'b111);
        chk("p0_e14_ch1", {level[1], rise[1], press[1], fall[1]}, 4'b0000);
        step(1);
        chk("p0_rise_1cyc", {level[0], rise[0]}, 2'b10);
        step(5);

        // Release from saturation
        in_v = 2'b00;
        step(13);
        chk("r0_e13", {level[0], fall[0], press[0]}, 3'b101);
        step(1);
        chk("r0_e14", {level[0], fall[0], press[0]}, 3'b010);
        step(1);
        chk("r0_fall_1cyc", fall[0], 1'b0);
        step(6);

        // Five-cycle glitch never reaches the high threshold
        in_v = 2'b01;
        step(5);
        in_v = 2'b00;
        for (int k = 0; k < 25; k++) begin
            step(1);
            chk("glitch", {level[0], rise[0], press[0]}, 3'b000);
        end

        // Toggle mode on channel 1: two press/release cycles
        mode_v = 2'b10;
        in_v   = 2'b10;
        step(14);
        chk("t1_rise1", {rise[1], press[1]}, 2'b11);
        step(5);
        in_v = 2'b00;
        step(14);
        chk("t1_fall1", {fall[1], level[1], press[1]}, 3'b101);
        step(6);
        in_v = 2'b10;
        step(14);
        chk("t1_rise2", {rise[1], press[1]}, 2'b10);
        step(5);
        in_v = 2'b00;
        step(14);
        chk("t1_fall2", {fall[1], press[1]}, 2'b10);
        step(6);

        // Auto-repeat on channel 0 (expected zero without the feature)
        in_v = 2'b01;
        step(14);
        chk("ar_rise", {rise[0], rpt[0]}, 2'b10);
        step(19);
        chk("ar_e19", rpt[0], 1'b0);
        step(1);
        chk("ar_e20", rpt[0], AR);
        step(1);
        chk("ar_e21", rpt[0], 1'b0);
        step(6);
        chk("ar_e27", rpt[0], 1'b0);
        step(1);
        chk("ar_e28", rpt[0], AR);
        step(8);
        chk("ar_e36", rpt[0], AR);
        in_v = 2'b00;
        for (int k = 1; k <= 13; k++) begin
            step(1);
            chk("ar_release_rpt", rpt[0], (k == 8) ? AR : 1'b0);
            chk("ar_release_fall", fall[0], 1'b0);
        end
        step(1);
        chk("ar_fall", {fall[0], level[0], rpt[0]}, 3'b100);
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk("ar_after_fall", rpt[0], 1'b0);
        end

        // Reset mid-press with cnt=10 on both channels
        mode_v = 2'b00;
        in_v   = 2'b11;
        step(12);
        rst = 1'b1;
        step(1);
        chk("mid_reset", {raw, level, press, rise, fall, rpt}, 32'h0);
        rst = 1'b0;
        step(13);
        chk("repress_e13", {level, rise}, 4'b0000);
        step(1);
        chk("repress_e14", {level, rise, press}, 6'b111111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
